// File: rtl/latch_rd_pkg.sv
// Shared types and sizing helpers for the latch window reader.
package latch_rd_pkg;

    // Window tracking states: IDLE waits for en, OPEN follows an active window.
    typedef enum logic {
        LR_IDLE = 1'b0,
        LR_OPEN = 1'b1
    } lr_state_e;

    // Occupancy counter width: must represent 0..DEPTH inclusive.
    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/latch_rd_fifo.sv
// Small synchronous FIFO. Push and pop may coincide at full and at empty.
// Pointers wrap modulo DEPTH; occupancy is a separate counter.
module latch_rd_fifo
    import latch_rd_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             head_o,
    output logic [lvl_width(DEPTH)-1:0]  level_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = lvl_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             pop_fire;
    logic             push_fire;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == LVL_W'(DEPTH));

    // A pop on an empty FIFO is ignored; a push into a full FIFO only lands
    // when a pop frees the head slot in the same edge.
    assign pop_fire  = pop_i && !empty_o;
    assign push_fire = push_i && (!full_o || pop_fire);

    // Next pointers and occupancy.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_fire) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop_fire) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; the head output is masked while empty, so stale contents are never visible.
        if (push_fire) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

    assign head_o  = empty_o ? '0 : mem_q[rptr_q];
    assign level_o = count_q;

endmodule

// File: rtl/latch_window_reader.sv
// Flop-only consumer of a latch enable window: mirrors the transparent-latch
// value, queues the held value on each window close, and streams it out.
module latch_window_reader
    import latch_rd_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [WIDTH-1:0]             d,
    output logic [WIDTH-1:0]             mirror_q,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [lvl_width(DEPTH)-1:0]  out_level,
    output logic [CNT_W-1:0]             drop_cnt,
    output logic                         window_open
);

    localparam int LVL_W = lvl_width(DEPTH);

    lr_state_e        state_q;
    logic             window_open_q;
    logic [WIDTH-1:0] mirror_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             close_evt;
    logic             pop_fire;
    logic             drop_evt;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_head;
    logic [LVL_W-1:0] fifo_level;

    // The window closes at the edge where en is sampled low while OPEN; the
    // value pushed is the mirror as it stood before that edge.
    assign close_evt = (state_q == LR_OPEN) && !en;
    assign pop_fire  = out_ready && !fifo_empty;
    assign drop_evt  = close_evt && fifo_full && !pop_fire;

    // Window FSM with registered window_open flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= LR_IDLE;
            window_open_q <= 1'b0;
        end else begin
            case (state_q)
                LR_IDLE: begin
                    if (en) begin
                        state_q       <= LR_OPEN;
                        window_open_q <= 1'b1;
                    end
                end
                LR_OPEN: begin
                    if (!en) begin
                        state_q       <= LR_IDLE;
                        window_open_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= LR_IDLE;
                    window_open_q <= 1'b0;
                end
            endcase
        end
    end

    // Latch model and saturating drop counter next state.
    always_comb begin
        mirror_d = en ? d : mirror_q;
        drop_d   = drop_q;
        if (drop_evt && (drop_q != {CNT_W{1'b1}})) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    // Mirror and drop counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mirror_q <= '0;
            drop_q   <= '0;
        end else begin
            mirror_q <= mirror_d;
            drop_q   <= drop_d;
        end
    end

    latch_rd_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (close_evt),
        .push_data_i (mirror_q),
        .pop_i       (out_ready),
        .head_o      (fifo_head),
        .level_o     (fifo_level),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign out_valid   = !fifo_empty;
    assign out_data    = fifo_head;
    assign out_level   = fifo_level;
    assign drop_cnt    = drop_q;
    assign window_open = window_open_q;

endmodule

// File: tb/tb_latch_window_reader.sv
// Directed, table-driven bench for latch_window_reader (WIDTH=4, DEPTH=2, CNT_W=2).
module tb_latch_window_reader;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] mirror_q;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_level;
    logic [CNT_W-1:0] drop_cnt;
    logic             window_open;

    int n_checks = 0;
    int n_bad    = 0;

    latch_window_reader #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .d           (d),
        .mirror_q    (mirror_q),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_level   (out_level),
        .drop_cnt    (drop_cnt),
        .window_open (window_open)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] d;
        logic       rdy;
        logic [3:0] mirror;
        logic       valid;
        logic [3:0] data;
        logic [1:0] level;
        logic [1:0] drop;
        logic       wopen;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int step, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic e, input logic [3:0] dv,
                                input logic rd, input logic [3:0] m, input logic v,
                                input logic [3:0] dat, input logic [1:0] lv,
                                input logic [1:0] dr, input logic wo);
        vec_t t;
        t.rst = r; t.en = e; t.d = dv; t.rdy = rd;
        t.mirror = m; t.valid = v; t.data = dat; t.level = lv; t.drop = dr; t.wopen = wo;
        vecs.push_back(t);
    endfunction

    // Drive one cycle's inputs, let one rising edge pass, then compare 1 time unit later.
    task automatic apply(input vec_t t, input int step);
        rst = t.rst; en = t.en; d = t.d; out_ready = t.rdy;
        @(posedge clk);
        #1;
        check("mirror_q",    step, 32'(mirror_q),    32'(t.mirror));
        check("out_valid",   step, 32'(out_valid),   32'(t.valid));
        check("out_data",    step, 32'(out_data),    32'(t.data));
        check("out_level",   step, 32'(out_level),   32'(t.level));
        check("drop_cnt",    step, 32'(drop_cnt),    32'(t.drop));
        check("window_open", step, 32'(window_open), 32'(t.wopen));
    endtask

    initial begin
        int step;
        vec_t t;
        int exp_drop;

        rst = 1'b1; en = 1'b0; d = '0; out_ready = 1'b0;

        //   rst en d    rdy  mir v  data lvl drop wo
        // reset
        add(1, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 0);
        // three-cycle window 3,5,9 then close -> 9 queued one edge after en=0
        add(0, 1, 4'h3, 0, 4'h3, 0, 4'h0, 0, 0, 1);
        add(0, 1, 4'h5, 0, 4'h5, 0, 4'h0, 0, 0, 1);
        add(0, 1, 4'h9, 0, 4'h9, 0, 4'h0, 0, 0, 1);
        add(0, 0, 4'h0, 0, 4'h9, 1, 4'h9, 1, 0, 0);
        add(0, 0, 4'h0, 1, 4'h9, 0, 4'h0, 0, 0, 0);
        // single-cycle window 0xA with out_ready held: no bypass, valid for one cycle
        add(0, 1, 4'hA, 1, 4'hA, 0, 4'h0, 0, 0, 1);
        add(0, 0, 4'h0, 1, 4'hA, 1, 4'hA, 1, 0, 0);
        add(0, 0, 4'h0, 1, 4'hA, 0, 4'h0, 0, 0, 0);
        // three windows 1,2,3 without ready -> holds 1,2, one drop, mirror 3
        add(0, 1, 4'h1, 0, 4'h1, 0, 4'h0, 0, 0, 1);
        add(0, 0, 4'h0, 0, 4'h1, 1, 4'h1, 1, 0, 0);
        add(0, 1, 4'h2, 0, 4'h2, 1, 4'h1, 1, 0, 1);
        add(0, 0, 4'h0, 0, 4'h2, 1, 4'h1, 2, 0, 0);
        add(0, 1, 4'h3, 0, 4'h3, 1, 4'h1, 2, 0, 1);
        add(0, 0, 4'h0, 0, 4'h3, 1, 4'h1, 2, 1, 0);
        // drain 1, 2, then ready while empty does nothing
        add(0, 0, 4'h0, 1, 4'h3, 1, 4'h2, 1, 1, 0);
        add(0, 0, 4'h0, 1, 4'h3, 0, 4'h0, 0, 1, 0);
        add(0, 0, 4'h0, 1, 4'h3, 0, 4'h0, 0, 1, 0);
        // refill 1,2, then close window 4 while popping: no drop, level stays 2
        add(0, 1, 4'h1, 0, 4'h1, 0, 4'h0, 0, 1, 1);
        add(0, 0, 4'h0, 0, 4'h1, 1, 4'h1, 1, 1, 0);
        add(0, 1, 4'h2, 0, 4'h2, 1, 4'h1, 1, 1, 1);
        add(0, 0, 4'h0, 0, 4'h2, 1, 4'h1, 2, 1, 0);
        add(0, 1, 4'h4, 0, 4'h4, 1, 4'h1, 2, 1, 1);
        add(0, 0, 4'h0, 1, 4'h4, 1, 4'h2, 2, 1, 0);
        add(0, 0, 4'h0, 1, 4'h4, 1, 4'h4, 1, 1, 0);
        add(0, 0, 4'h0, 1, 4'h4, 0, 4'h0, 0, 1, 0);

        step = 0;
        foreach (vecs[i]) begin
            apply(vecs[i], step);
            step++;
        end

        // Saturation: refill with 7 and 8, then five more windows all dropped.
        exp_drop = 1;
        t.rst = 0; t.rdy = 0; t.valid = 1; t.data = 4'h7;
        t.en = 1; t.d = 4'h7; t.mirror = 4'h7; t.valid = 0; t.data = 4'h0;
        t.level = 0; t.drop = 2'(exp_drop); t.wopen = 1;
        apply(t, step++);
        t.en = 0; t.valid = 1; t.data = 4'h7; t.level = 1; t.wopen = 0;
        apply(t, step++);
        t.en = 1; t.d = 4'h8; t.mirror = 4'h8; t.wopen = 1;
        apply(t, step++);
        t.en = 0; t.level = 2; t.wopen = 0;
        apply(t, step++);
        for (int w = 0; w < 5; w++) begin
            t.en = 1; t.d = 4'(w + 10); t.mirror = 4'(w + 10); t.wopen = 1;
            apply(t, step++);
            exp_drop = (exp_drop < 3) ? exp_drop + 1 : 3;
            t.en = 0; t.drop = 2'(exp_drop); t.wopen = 0;
            apply(t, step++);
        end
        check("drop_saturated", step, 32'(drop_cnt), 32'd3);

        // Reset mid-window and mid-occupancy; the window reopens right after reset.
        t.rst = 0; t.en = 1; t.d = 4'h6; t.rdy = 0;
        t.mirror = 4'h6; t.valid = 1; t.data = 4'h7; t.level = 2; t.drop = 3; t.wopen = 1;
        apply(t, step++);
        t.rst = 1; t.mirror = 4'h0; t.valid = 0; t.data = 4'h0; t.level = 0; t.drop = 0;
        t.wopen = 0;
        apply(t, step++);
        t.rst = 0; t.mirror = 4'h6; t.wopen = 1;
        apply(t, step++);
        t.en = 0; t.d = 4'h0; t.valid = 1; t.data = 4'h6; t.level = 1; t.wopen = 0;
        apply(t, step++);
        t.rdy = 1; t.valid = 0; t.data = 4'h0; t.level = 0;
        apply(t, step++);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
